// File: rtl/wb_stage.sv
// Write-back stage: takes the memory-stage payload, aligns and extends load data, and drives the
// register-file write port, the forwarding view of the occupant and the debug trace.
module wb_stage #(
   parameter int PC_W  = 32,
   parameter int RF_AW = 5
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             ms_to_ws_valid,
   output logic             ws_allowin,
   input  logic [PC_W-1:0]  ms_pc,
   input  logic [RF_AW-1:0] ms_rd,
   input  logic             ms_reg_write,
   input  logic [2:0]       ms_load_op,
   input  logic [1:0]       ms_addr_low,
   input  logic [31:0]      ms_alu_result,
   input  logic [31:0]      data_sram_rdata,
   input  logic             trace_stall,
   output logic             ws_valid,
   output logic [RF_AW-1:0] ws_rd,
   output logic             ws_reg_write,
   output logic [3:0]       ws_rf_wen,
   output logic [31:0]      ws_rf_wdata,
   output logic             rf_we,
   output logic [PC_W-1:0]  debug_wb_pc,
   output logic [3:0]       debug_wb_rf_wen,
   output logic [RF_AW-1:0] debug_wb_rf_wnum,
   output logic [31:0]      debug_wb_rf_wdata
);

   localparam logic [2:0] LD_NONE = 3'd0;
   localparam logic [2:0] LD_LB   = 3'd1;
   localparam logic [2:0] LD_LBU  = 3'd2;
   localparam logic [2:0] LD_LH   = 3'd3;
   localparam logic [2:0] LD_LHU  = 3'd4;
   localparam logic [2:0] LD_LW   = 3'd5;
   localparam logic [2:0] LD_LWL  = 3'd6;
   localparam logic [2:0] LD_LWR  = 3'd7;

   logic             ws_valid_r;
   logic             first_cycle_r;
   logic [PC_W-1:0]  pc_r;
   logic [RF_AW-1:0] rd_r;
   logic             reg_write_r;
   logic [2:0]       load_op_r;
   logic [1:0]       addr_low_r;
   logic [31:0]      alu_result_r;
   logic [31:0]      rdata_buf_r;
   logic             rdata_buf_valid_r;

   logic             ws_ready_go_s;
   logic             allowin_s;
   logic             accept_s;
   logic             retire_s;
   logic [31:0]      raw_s;
   logic [7:0]       byte_s;
   logic [15:0]      half_s;
   logic [31:0]      wdata_s;
   logic [3:0]       mask_s;
   logic             rf_we_s;

   assign ws_ready_go_s = ~trace_stall;
   assign allowin_s     = ~ws_valid_r | ws_ready_go_s;
   assign accept_s      = ms_to_ws_valid & allowin_s;
   assign retire_s      = ws_valid_r & ws_ready_go_s;

   // The SRAM only presents load data in the first WS cycle; afterwards the captured copy is used.
   assign raw_s = rdata_buf_valid_r ? rdata_buf_r : data_sram_rdata;

   // Occupancy and first-cycle tracking for the current WS instruction
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ws_valid_r    <= 1'b0;
         first_cycle_r <= 1'b0;
      end else if (accept_s) begin
         ws_valid_r    <= 1'b1;
         first_cycle_r <= 1'b1;
      end else begin
         ws_valid_r    <= retire_s ? 1'b0 : ws_valid_r;
         first_cycle_r <= 1'b0;
      end
   end

   // Payload capture on accept
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pc_r         <= {PC_W{1'b0}};
         rd_r         <= {RF_AW{1'b0}};
         reg_write_r  <= 1'b0;
         load_op_r    <= LD_NONE;
         addr_low_r   <= 2'd0;
         alu_result_r <= 32'd0;
      end else if (accept_s) begin
         pc_r         <= ms_pc;
         rd_r         <= ms_rd;
         reg_write_r  <= ms_reg_write;
         load_op_r    <= ms_load_op;
         addr_low_r   <= ms_addr_low;
         alu_result_r <= ms_alu_result;
      end
   end

   // Hold the load data of a stalled first cycle until the instruction retires
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata_buf_r       <= 32'd0;
         rdata_buf_valid_r <= 1'b0;
      end else if (retire_s) begin
         rdata_buf_valid_r <= 1'b0;
      end else if (ws_valid_r && first_cycle_r && (load_op_r != LD_NONE)) begin
         rdata_buf_r       <= data_sram_rdata;
         rdata_buf_valid_r <= 1'b1;
      end
   end

   // Byte/halfword pick, extension and lwl/lwr alignment
   always_comb begin
      byte_s  = 8'h00;
      half_s  = 16'h0000;
      wdata_s = alu_result_r;
      case (addr_low_r)
         2'd0:    byte_s = raw_s[7:0];
         2'd1:    byte_s = raw_s[15:8];
         2'd2:    byte_s = raw_s[23:16];
         2'd3:    byte_s = raw_s[31:24];
         default: byte_s = 8'h00;
      endcase
      if (addr_low_r[1]) begin
         half_s = raw_s[31:16];
      end else begin
         half_s = raw_s[15:0];
      end
      case (load_op_r)
         LD_LB:   wdata_s = {{24{byte_s[7]}}, byte_s};
         LD_LBU:  wdata_s = {24'h000000, byte_s};
         LD_LH:   wdata_s = {{16{half_s[15]}}, half_s};
         LD_LHU:  wdata_s = {16'h0000, half_s};
         LD_LW:   wdata_s = raw_s;
         LD_LWL:  wdata_s = raw_s << {~addr_low_r, 3'b000};
         LD_LWR:  wdata_s = raw_s >> {addr_low_r, 3'b000};
         default: wdata_s = alu_result_r;
      endcase
   end

   // Byte write mask: partial-word loads merge with the old register value in the RF
   always_comb begin
      mask_s = 4'b1111;
      case (load_op_r)
         LD_LWL: begin
            case (addr_low_r)
               2'd0:    mask_s = 4'b1000;
               2'd1:    mask_s = 4'b1100;
               2'd2:    mask_s = 4'b1110;
               default: mask_s = 4'b1111;
            endcase
         end
         LD_LWR: begin
            case (addr_low_r)
               2'd0:    mask_s = 4'b1111;
               2'd1:    mask_s = 4'b0111;
               2'd2:    mask_s = 4'b0011;
               default: mask_s = 4'b0001;
            endcase
         end
         default: mask_s = 4'b1111;
      endcase
   end

   assign rf_we_s = retire_s & reg_write_r & (rd_r != {RF_AW{1'b0}});

   assign ws_allowin        = allowin_s;
   assign ws_valid          = ws_valid_r;
   assign ws_rd             = rd_r;
   assign ws_reg_write      = reg_write_r;
   assign ws_rf_wen         = mask_s;
   assign ws_rf_wdata       = wdata_s;
   assign rf_we             = rf_we_s;
   assign debug_wb_pc       = pc_r;
   assign debug_wb_rf_wen   = {4{rf_we_s}} & mask_s;
   assign debug_wb_rf_wnum  = rd_r;
   assign debug_wb_rf_wdata = wdata_s;

endmodule
